// File: rtl/start_screen_draw.sv
// start_screen_draw
//   Overlays the 64x64 start-screen image on the VGA timing/colour stream.
//   Issues the image ROM address one clock after the pixel and consumes the
//   ROM's registered data one clock after that. The pixel reaches the output
//   three clocks after it enters. A frame-counting blink FSM gives the
//   "press to start" effect.
//
//   Parameters: XPOS/YPOS (image top-left corner), SCALE_LOG2 (upscale by
//   2**SCALE_LOG2), BLINK_FRAMES (frames per blink phase, 0 = never blink).
//
//   Optional build macro: START_SCREEN_TRANSPARENT_EN -- when defined, ROM
//   pixels equal to 12'hF0F are transparent and show the background.
//
//   Ports:
//     clk, rst_n            pixel clock, async active-low reset
//     enable                1 = overlay active, 0 = pass-through + blink reset
//     hcount/vcount_in      pixel position
//     h/vsync_in, h/vblnk_in, rgb_in   upstream timing and background colour
//     rom_addr              registered ROM address {y[5:0], x[5:0]}
//     rom_rgb               ROM data, valid one clock after rom_addr
//     *_out                 timing delayed 3 clocks, final colour
module start_screen_draw #(
    parameter int XPOS         = 300,
    parameter int YPOS         = 200,
    parameter int SCALE_LOG2   = 0,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [11:0] rom_addr,
    input  logic [11:0] rom_rgb,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    localparam int unsigned WIN = 64 << SCALE_LOG2;
    // 12-bit bounds so XPOS + WIN cannot wrap past the 11-bit counters.
    localparam logic [11:0] X_LO  = 12'(XPOS);
    localparam logic [11:0] X_HI  = 12'(XPOS + WIN);
    localparam logic [11:0] Y_LO  = 12'(YPOS);
    localparam logic [11:0] Y_HI  = 12'(YPOS + WIN);
    localparam logic [10:0] X_OFF = 11'(XPOS);
    localparam logic [10:0] Y_OFF = 11'(YPOS);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (BLINK_FRAMES > 0) ? CNT_W'(BLINK_FRAMES - 1) : '0;

    typedef enum logic {SHOW = 1'b0, HIDE = 1'b1} phase_e;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } timing_t;

    // Everything the output stage needs travels with its pixel, so a blink
    // toggle or enable change never affects a pixel already in flight.
    typedef struct packed {
        timing_t tim;
        logic    win;
        logic    en;
        phase_e  phase;
    } stage_t;

    stage_t            s1_d, s1_q, s2_d, s2_q;
    timing_t           out_d, out_q;
    logic [11:0]       rom_addr_d, rom_addr_q;
    logic              vsync_prev_d, vsync_prev_q;
    logic [CNT_W-1:0]  frame_cnt_d, frame_cnt_q;
    phase_e            phase_d, phase_q;

    logic [10:0] dx, dy;
    logic        h_in, v_in, win, rom_draw;

    always_comb begin
        // Stage 1: window test and ROM address
        dx   = hcount_in - X_OFF;
        dy   = vcount_in - Y_OFF;
        h_in = ({1'b0, hcount_in} >= X_LO) && ({1'b0, hcount_in} < X_HI);
        v_in = ({1'b0, vcount_in} >= Y_LO) && ({1'b0, vcount_in} < Y_HI);
        win  = h_in && v_in && !hblnk_in && !vblnk_in;
        rom_addr_d = win ? {6'(dy >> SCALE_LOG2), 6'(dx >> SCALE_LOG2)} : '0;

        s1_d.tim.hcount = hcount_in;
        s1_d.tim.vcount = vcount_in;
        s1_d.tim.hsync  = hsync_in;
        s1_d.tim.vsync  = vsync_in;
        s1_d.tim.hblnk  = hblnk_in;
        s1_d.tim.vblnk  = vblnk_in;
        s1_d.tim.rgb    = rgb_in;
        s1_d.win        = win;
        s1_d.en         = enable;
        s1_d.phase      = phase_q;

        // Stage 2: wait for the ROM's registered output
        s2_d = s1_q;

        // Stage 3: colour mux
        rom_draw = s2_q.win && s2_q.en && (s2_q.phase == SHOW);
`ifdef START_SCREEN_TRANSPARENT_EN
        if (rom_rgb == 12'hF0F) rom_draw = 1'b0;
`endif
        out_d     = s2_q.tim;
        out_d.rgb = rom_draw ? rom_rgb : s2_q.tim.rgb;

        // Blink FSM, advanced on each vsync rising edge while enabled
        vsync_prev_d = vsync_in;
        frame_cnt_d  = frame_cnt_q;
        phase_d      = phase_q;
        if (!enable) begin
            frame_cnt_d = '0;
            phase_d     = SHOW;
        end else if ((BLINK_FRAMES > 0) && vsync_in && !vsync_prev_q) begin
            if (frame_cnt_q == CNT_LAST) begin
                frame_cnt_d = '0;
                phase_d     = (phase_q == SHOW) ? HIDE : SHOW;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q         <= '0;
            s2_q         <= '0;
            out_q        <= '0;
            rom_addr_q   <= '0;
            vsync_prev_q <= 1'b0;
            frame_cnt_q  <= '0;
            phase_q      <= SHOW;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            out_q        <= out_d;
            rom_addr_q   <= rom_addr_d;
            vsync_prev_q <= vsync_prev_d;
            frame_cnt_q  <= frame_cnt_d;
            phase_q      <= phase_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign hcount_out = out_q.hcount;
    assign vcount_out = out_q.vcount;
    assign hsync_out  = out_q.hsync;
    assign vsync_out  = out_q.vsync;
    assign hblnk_out  = out_q.hblnk;
    assign vblnk_out  = out_q.vblnk;
    assign rgb_out    = out_q.rgb;

endmodule

// File: tb/tb_start_screen_draw.sv
// Testbench for start_screen_draw: two instances (scale 1x with blinking,
// scale 2x without blinking) share one input stream; each has its own ROM
// model. A frame-level reference model predicts every output.
module tb_start_screen_draw;

    localparam int P_X = 100;
    localparam int P_Y = 200;
    localparam int S0  = 0;
    localparam int B0  = 2;
    localparam int S1  = 1;
    localparam int B1  = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, enable, hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [10:0] hcount_in, vcount_in;
    logic [11:0] rgb_in;

    logic [11:0] rom_addr0, rom_addr1;
    logic [11:0] rom_rgb0 = '0;
    logic [11:0] rom_rgb1 = '0;
    logic [10:0] hcount_out0, vcount_out0, hcount_out1, vcount_out1;
    logic        hsync_out0, vsync_out0, hblnk_out0, vblnk_out0;
    logic        hsync_out1, vsync_out1, hblnk_out1, vblnk_out1;
    logic [11:0] rgb_out0, rgb_out1;

    start_screen_draw #(.XPOS(P_X), .YPOS(P_Y), .SCALE_LOG2(S0), .BLINK_FRAMES(B0)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
        .rom_addr(rom_addr0), .rom_rgb(rom_rgb0),
        .hcount_out(hcount_out0), .vcount_out(vcount_out0),
        .hsync_out(hsync_out0), .vsync_out(vsync_out0),
        .hblnk_out(hblnk_out0), .vblnk_out(vblnk_out0), .rgb_out(rgb_out0)
    );

    start_screen_draw #(.XPOS(P_X), .YPOS(P_Y), .SCALE_LOG2(S1), .BLINK_FRAMES(B1)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
        .rom_addr(rom_addr1), .rom_rgb(rom_rgb1),
        .hcount_out(hcount_out1), .vcount_out(vcount_out1),
        .hsync_out(hsync_out1), .vsync_out(vsync_out1),
        .hblnk_out(hblnk_out1), .vblnk_out(vblnk_out1), .rgb_out(rgb_out1)
    );

    // Image content: arbitrary colours, every address with low nibble A is
    // the magenta key.
    function automatic logic [11:0] rom_f(input logic [11:0] a);
        logic [11:0] t;
        t = a * 12'd5 + 12'h3C1;
        return (a[3:0] == 4'hA) ? 12'hF0F : t;
    endfunction

    always @(posedge clk) begin
        rom_rgb0 <= rom_f(rom_addr0);
        rom_rgb1 <= rom_f(rom_addr1);
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [10:0] h, v;
        logic [3:0]  tim;   // {hsync, vsync, hblnk, vblnk}
        logic [11:0] addr0, addr1, out0, out1;
    } rec_t;

    rec_t hist[$];
    int   edges = 0;        // vsync edges seen while enabled since last clear
    bit   vs_prev = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic bit in_win(int h, int v, bit hb, bit vb, int s);
        int w;
        w = 64 << s;
        return (h >= P_X) && (h < P_X + w) && (v >= P_Y) && (v < P_Y + w) && !hb && !vb;
    endfunction

    function automatic logic [11:0] img_addr(int h, int v, int s);
        return 12'((((v - P_Y) >> s) * 64) + ((h - P_X) >> s));
    endfunction

    function automatic logic [11:0] ref_rgb(bit w, logic [11:0] a, bit en, int b,
                                            logic [11:0] bg);
        bit          shown;
        logic [11:0] rv;
        shown = (b == 0) || (((edges / b) % 2) == 0);
        rv    = rom_f(a);
        shown = shown && w && en;
`ifdef START_SCREEN_TRANSPARENT_EN
        if (rv == 12'hF0F) shown = 1'b0;
`endif
        return shown ? rv : bg;
    endfunction

    task automatic model_push();
        rec_t r;
        int   hi, vi, n;
        bit   w0, w1;
        r = '{default: '0};
        if (!rst_n) begin
            edges   = 0;
            vs_prev = 1'b0;
            hist.push_back(r);
            n = hist.size();
            hist[n-2] = r;
            hist[n-3] = r;
        end else begin
            hi = int'(hcount_in);
            vi = int'(vcount_in);
            w0 = in_win(hi, vi, hblnk_in, vblnk_in, S0);
            w1 = in_win(hi, vi, hblnk_in, vblnk_in, S1);
            r.h     = hcount_in;
            r.v     = vcount_in;
            r.tim   = {hsync_in, vsync_in, hblnk_in, vblnk_in};
            r.addr0 = w0 ? img_addr(hi, vi, S0) : 12'h000;
            r.addr1 = w1 ? img_addr(hi, vi, S1) : 12'h000;
            r.out0  = ref_rgb(w0, r.addr0, enable, B0, rgb_in);
            r.out1  = ref_rgb(w1, r.addr1, enable, B1, rgb_in);
            hist.push_back(r);
            if (!enable) edges = 0;
            else if (vsync_in && !vs_prev) edges++;
            vs_prev = vsync_in;
        end
    endtask

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_zero();
        chk("rst_addr0", rom_addr0, 12'h000);
        chk("rst_addr1", rom_addr1, 12'h000);
        chk("rst_h0", 12'(hcount_out0), 12'h000);
        chk("rst_v0", 12'(vcount_out0), 12'h000);
        chk("rst_tim0", 12'({hsync_out0, vsync_out0, hblnk_out0, vblnk_out0}), 12'h000);
        chk("rst_rgb0", rgb_out0, 12'h000);
        chk("rst_rgb1", rgb_out1, 12'h000);
        chk("rst_tim1", 12'({hsync_out1, vsync_out1, hblnk_out1, vblnk_out1}), 12'h000);
    endtask

    task automatic check_pipe();
        int   n;
        rec_t e;
        n = hist.size();
        e = hist[n-3];
        chk("addr0", rom_addr0, hist[n-1].addr0);
        chk("addr1", rom_addr1, hist[n-1].addr1);
        chk("hcount0", 12'(hcount_out0), 12'(e.h));
        chk("vcount0", 12'(vcount_out0), 12'(e.v));
        chk("timing0", 12'({hsync_out0, vsync_out0, hblnk_out0, vblnk_out0}), 12'(e.tim));
        chk("rgb0", rgb_out0, e.out0);
        chk("hcount1", 12'(hcount_out1), 12'(e.h));
        chk("timing1", 12'({hsync_out1, vsync_out1, hblnk_out1, vblnk_out1}), 12'(e.tim));
        chk("rgb1", rgb_out1, e.out1);
    endtask

    // Called just after an active edge with the new inputs already driven.
    task automatic step();
        model_push();
        if (!rst_n) begin
            #1;
            check_zero();
        end
        @(posedge clk);
        #1;
        check_pipe();
    endtask

    task automatic drive(input bit r, input bit en, input int h, input int v,
                         input bit hs, input bit vs, input bit hb, input bit vb,
                         input logic [11:0] rgb);
        rst_n     = r;
        enable    = en;
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hsync_in  = hs;
        vsync_in  = vs;
        hblnk_in  = hb;
        vblnk_in  = vb;
        rgb_in    = rgb;
    endtask

    // One pixel followed by two idle pixels, then check dut0's colour.
    task automatic probe(input string nm, input bit en, input int h, input int v,
                         input logic [11:0] rgb, input logic [11:0] want);
        drive(1, en, h, v, 0, 0, 0, 0, rgb);
        step();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 12'h000);
        step();
        step();
        chk(nm, rgb_out0, want);
    endtask

    task automatic vs_pulse(input bit en);
        drive(1, en, 0, 0, 0, 1, 0, 0, 12'h000);
        step();
        drive(1, en, 0, 0, 0, 0, 0, 0, 12'h000);
        step();
    endtask

    task automatic do_reset();
        drive(0, 1, 0, 0, 0, 0, 0, 0, 12'h000);
        step();
        step();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 12'h000);
        step();
    endtask

    typedef struct {
        int          h, v;
        bit          hb, vb;
        logic [11:0] a0, a1;
    } vec_t;

    vec_t tbl[13];
    bit   hs_pat[6];
    bit   vs_r;
    logic [11:0] want;

    initial begin
        tbl[0]  = '{100, 200, 0, 0, 12'h000, 12'h000};
        tbl[1]  = '{163, 263, 0, 0, 12'hFFF, 12'h7DF};
        tbl[2]  = '{164, 263, 0, 0, 12'h000, 12'h7E0};
        tbl[3]  = '{ 99, 200, 0, 0, 12'h000, 12'h000};
        tbl[4]  = '{103, 205, 0, 0, 12'h143, 12'h081};
        tbl[5]  = '{227, 327, 0, 0, 12'h000, 12'hFFF};
        tbl[6]  = '{228, 250, 0, 0, 12'h000, 12'h000};
        tbl[7]  = '{120, 220, 1, 0, 12'h000, 12'h000};
        tbl[8]  = '{120, 220, 0, 1, 12'h000, 12'h000};
        tbl[9]  = '{120, 199, 0, 0, 12'h000, 12'h000};
        tbl[10] = '{120, 264, 0, 0, 12'h000, 12'h80A};
        tbl[11] = '{120, 328, 0, 0, 12'h000, 12'h000};
        tbl[12] = '{120, 220, 0, 0, 12'h514, 12'h28A};

        for (int i = 0; i < 3; i++) hist.push_back('{default: '0});
        drive(0, 0, 0, 0, 0, 0, 0, 0, 12'h000);
        @(posedge clk);
        #1;
        do_reset();

        // Address table
        for (int i = 0; i < 13; i++) begin
            drive(1, 1, tbl[i].h, tbl[i].v, 0, 0, tbl[i].hb, tbl[i].vb, 12'($urandom));
            step();
            chk($sformatf("tbl%0d_addr0", i), rom_addr0, tbl[i].a0);
            chk($sformatf("tbl%0d_addr1", i), rom_addr1, tbl[i].a1);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 0, 0, 0, 0, 12'h000);
            step();
        end

        // Window edges and colour key, phase is SHOW here
        do_reset();
        probe("corner_tl", 1, 100, 200, 12'h123, rom_f(12'h000));
        probe("corner_br", 1, 163, 263, 12'h234, rom_f(12'hFFF));
        probe("right_out", 1, 164, 263, 12'h456, 12'h456);
        probe("left_out", 1, 99, 200, 12'h567, 12'h567);
        probe("enable_off", 0, 120, 220, 12'h678, 12'h678);
`ifdef START_SCREEN_TRANSPARENT_EN
        want = 12'h123;
`else
        want = 12'hF0F;
`endif
        probe("key_F0F", 1, 110, 200, 12'h123, want);

        // Blinking: two frames shown, two hidden
        do_reset();
        for (int i = 0; i < 8; i++) begin
            probe($sformatf("blink_f%0d", i), 1, 120, 220, 12'h123,
                  ((i % 4) < 2) ? 12'hD25 : 12'h123);
            vs_pulse(1);
        end
        vs_pulse(1);
        vs_pulse(1);
        probe("blink_hidden", 1, 120, 220, 12'h123, 12'h123);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 12'h000);
        step();
        vs_pulse(1);
        probe("reenable_shown", 1, 120, 220, 12'h123, 12'hD25);

        // Reset in the middle of the window
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 120 + i, 220, 1, 0, 0, 0, 12'h3AB);
            step();
        end
        drive(0, 1, 122, 220, 1, 0, 0, 0, 12'h3AB);
        step();
        hs_pat = '{1, 0, 1, 1, 0, 1};
        for (int j = 0; j < 6; j++) begin
            drive(1, 1, 130, 220, hs_pat[j], 0, 0, 0, 12'h3AB);
            step();
            if (j < 2) chk("post_rst_hs_fill", 12'(hsync_out0), 12'h000);
            else       chk("post_rst_hs_lag", 12'(hsync_out0), 12'(hs_pat[j-2]));
        end

        // Random traffic against the model
        vs_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) vs_r = !vs_r;
            drive($urandom_range(0, 199) != 0, $urandom_range(0, 7) != 0,
                  $urandom_range(80, 240), $urandom_range(180, 340),
                  $urandom_range(0, 1) == 1, vs_r,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                  12'($urandom));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
